linear_interp_n: RTL and testbench

Upsampling linear interpolator: the rate-raising counterpart of the moving-average smoother. It accepts signed `word_width` samples at a slow, valid-strobed rate and emits 2^`interp_pow` linearly interpolated samples per input interval. Each output is paced by an external output tick. It sits between slow control-loop outputs (lock setpoints, scan ramps) and the DAC write path, replacing step changes with ramps.

---
 rtl/opo_package.sv | 13 +
 rtl/linear_interp_n_if.sv | 25 ++
 rtl/linear_interp_n.sv | 157 +++++++++++++++
 tb/tb_linear_interp_n.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/opo_package.sv
// Shared definitions for the opo signal path: sample word width and the
// interpolator/ramp state encoding.
package opo_package;

  localparam int word_width = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    RUN   = 2'd2
  } interp_state_t;

endpackage

// File: rtl/linear_interp_n_if.sv
// Sample-in / tick / sample-out bundle for the linear interpolator.
// Handshake: an input transfer happens on a rising edge where sample_in_valid && sample_in_ready.
interface linear_interp_n_if;
  import opo_package::*;

  logic                         enable;
  logic signed [word_width-1:0] sample_in;
  logic                         sample_in_valid;
  logic                         sample_in_ready;
  logic                         out_tick;
  logic signed [word_width-1:0] sample_out;
  logic                         sample_out_valid;
  interp_state_t                dbg_state;

  modport slave (
    input  enable, sample_in, sample_in_valid, out_tick,
    output sample_in_ready, sample_out, sample_out_valid, dbg_state
  );

  modport master (
    output enable, sample_in, sample_in_valid, out_tick,
    input  sample_in_ready, sample_out, sample_out_valid, dbg_state
  );

endinterface

// File: rtl/linear_interp_n.sv
// Upsampling linear interpolator: 2^interp_pow ramp samples per input interval,
// one output per out_tick, with a one-entry pending slot for the next endpoint.
module linear_interp_n
  import opo_package::*;
#(
  parameter int interp_pow = 2
) (
  input  logic              clk,
  input  logic              rst,
  linear_interp_n_if.slave  bus
);

  localparam int W  = word_width;
  localparam int P  = interp_pow;
  localparam int N  = 1 << P;
  localparam int AW = W + P + 1;

  interp_state_t         state_q, state_d;
  logic signed [W-1:0]   x0_q, x0_d;
  logic signed [W-1:0]   x1_q, x1_d;
  logic signed [W-1:0]   pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic signed [W:0]     delta_q, delta_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [P-1:0]          k_q, k_d;
  logic signed [W-1:0]   out_q, out_d;
  logic                  out_valid_q, out_valid_d;

  logic                  ready;
  logic                  accept;
  logic                  last_phase;
  logic signed [W:0]     delta_new;
  logic signed [AW-1:0]  delta_new_ext;
  logic signed [AW-1:0]  delta_q_ext;
  logic signed [AW-1:0]  x1_scaled;

  // Ready depends only on registered slot occupancy, so an accept and a
  // consume can never land in the same cycle.
  assign ready  = bus.enable ? ~pend_valid_q : 1'b1;
  assign accept = bus.sample_in_valid && ready;

  assign last_phase    = (k_q == P'(N - 1));
  assign delta_new     = {pend_q[W-1], pend_q} - {x1_q[W-1], x1_q};
  assign delta_new_ext = {{P{delta_new[W]}}, delta_new};
  assign delta_q_ext   = {{P{delta_q[W]}}, delta_q};
  assign x1_scaled     = {x1_q[W-1], x1_q, {P{1'b0}}};

  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    delta_d      = delta_q;
    acc_d        = acc_q;
    k_d          = k_q;
    out_d        = out_q;
    out_valid_d  = 1'b0;

    if (!bus.enable) begin
      state_d      = EMPTY;
      pend_valid_d = 1'b0;
      out_d        = bus.sample_in;
      out_valid_d  = bus.sample_in_valid;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (bus.sample_in_valid) begin
            x1_d    = bus.sample_in;
            state_d = HOLD;
          end
        end

        HOLD: begin
          if (accept) begin
            pend_d       = bus.sample_in;
            pend_valid_d = 1'b1;
          end
          if (bus.out_tick) begin
            out_d       = x1_q;
            out_valid_d = 1'b1;
            if (pend_valid_q) begin
              // This tick already emitted phase 0, so start the ramp at phase 1.
              x0_d         = x1_q;
              x1_d         = pend_q;
              delta_d      = delta_new;
              acc_d        = x1_scaled + delta_new_ext;
              k_d          = P'(1);
              pend_valid_d = 1'b0;
              state_d      = RUN;
            end
          end
        end

        RUN: begin
          if (accept) begin
            pend_d       = bus.sample_in;
            pend_valid_d = 1'b1;
          end
          if (bus.out_tick) begin
            out_d       = acc_q[W-1+P:P];
            out_valid_d = 1'b1;
            acc_d       = acc_q + delta_q_ext;
            k_d         = k_q + P'(1);
            if (last_phase) begin
              k_d = '0;
              if (pend_valid_q) begin
                // Next segment resumes at phase 0, which emits the old x1.
                x0_d         = x1_q;
                x1_d         = pend_q;
                delta_d      = delta_new;
                acc_d        = x1_scaled;
                pend_valid_d = 1'b0;
              end else begin
                state_d = HOLD;
              end
            end
          end
        end

        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      x0_q         <= '0;
      x1_q         <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      delta_q      <= '0;
      acc_q        <= '0;
      k_q          <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      delta_q      <= delta_d;
      acc_q        <= acc_d;
      k_q          <= k_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.sample_in_ready  = ready;
  assign bus.sample_out       = out_q;
  assign bus.sample_out_valid = out_valid_q;
  assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_linear_interp_n.sv
// Bench for linear_interp_n: directed ramps from the test plan plus random
// traffic checked against a sample-list reference model.
module tb_linear_interp_n;
  import opo_package::*;

  localparam int W = word_width;
  localparam int P = 2;
  localparam int N = 1 << P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  linear_interp_n_if bus ();

  linear_interp_n #(.interp_pow(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: list of accepted samples, cursor (mj, mk) and index ml of
  // the sample most recently taken out of the pending slot.
  longint              s_q[$];
  int                  mj, mk, ml;
  logic [W-1:0]        exp_q[$];
  logic signed [W-1:0] got_q[$];

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic bit model_ready();
    return (s_q.size() == 0) || (ml == s_q.size() - 1);
  endfunction

  task automatic model_clear();
    s_q.delete();
    exp_q.delete();
    mj = 0;
    mk = 0;
    ml = 0;
  endtask

  task automatic model_tick();
    longint v;
    if (s_q.size() == 0) return;
    if (mk == 0) begin
      v = s_q[mj];
      if (s_q.size() > mj + 1) begin
        mk = 1;
        ml = mj + 1;
      end
    end else begin
      v = s_q[mj] + floor_div(longint'(mk) * (s_q[mj+1] - s_q[mj]), N);
      if (mk == N - 1) begin
        mj++;
        mk = 0;
        if (s_q.size() > mj + 1) ml = mj + 1;
      end else begin
        mk++;
      end
    end
    exp_q.push_back(W'(v));
  endtask

  task automatic cycle(input logic tick, input logic vld, input logic signed [W-1:0] din);
    logic         exp_rdy;
    logic [W-1:0] e;
    @(negedge clk);
    bus.out_tick        = tick;
    bus.sample_in_valid = vld;
    bus.sample_in       = din;
    exp_rdy = bus.enable ? model_ready() : 1'b1;
    check("ready", bus.sample_in_ready, exp_rdy);
    @(posedge clk);
    if (!bus.enable) begin
      model_clear();
      if (vld) exp_q.push_back(din);
    end else begin
      if (tick) model_tick();
      if (vld && exp_rdy) s_q.push_back(din);
    end
    #1;
    check("out_valid", bus.sample_out_valid, exp_q.size() != 0);
    if (bus.sample_out_valid) got_q.push_back(bus.sample_out);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sample_out", bus.sample_out, $signed(e));
    end
  endtask

  task automatic do_reset(input logic tick);
    @(negedge clk);
    rst                 = 1'b1;
    bus.out_tick        = tick;
    bus.sample_in_valid = 1'b0;
    @(posedge clk);
    model_clear();
    #1;
    check("rst_out", bus.sample_out, 0);
    check("rst_valid", bus.sample_out_valid, 0);
    check("rst_ready", bus.sample_in_ready, 1);
    rst = 1'b0;
  endtask

  task automatic ramp_test(input string tag, input longint a, input longint b,
                           input longint e0, input longint e1, input longint e2,
                           input longint e3, input longint e4);
    longint ev[5];
    ev = '{e0, e1, e2, e3, e4};
    do_reset(1'b0);
    got_q.delete();
    cycle(1'b0, 1'b1, W'(a));
    cycle(1'b0, 1'b1, W'(b));
    repeat (5) cycle(1'b1, 1'b0, '0);
    check({tag, "_count"}, got_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check(tag, (i < got_q.size()) ? longint'(got_q[i]) : -999999, ev[i]);
  endtask

  initial begin
    longint seq_a[10];
    bus.enable          = 1'b1;
    bus.out_tick        = 1'b0;
    bus.sample_in_valid = 1'b0;
    bus.sample_in       = '0;
    model_clear();

    // Continuous ticks: 0 repeated in HOLD, then the ramp to 100.
    do_reset(1'b1);
    got_q.delete();
    cycle(1'b1, 1'b1, 16'sd0);
    repeat (3) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 16'sd100);
    repeat (6) cycle(1'b1, 1'b0, '0);
    seq_a = '{0, 0, 0, 0, 0, 25, 50, 75, 100, 100};
    check("cont_count", got_q.size(), 10);
    for (int i = 0; i < 10; i++)
      check("cont", (i < got_q.size()) ? longint'(got_q[i]) : -999999, seq_a[i]);

    ramp_test("down",     100, -100,  100,   50,     0,    -50, -100);
    ramp_test("floor_p",    0,    3,    0,    0,     1,      2,    3);
    ramp_test("floor_n",    0,   -3,    0,   -1,    -2,     -3,   -3);
    ramp_test("fullscale", 32767, -32768, 32767, 16383, -1, -16385, -32768);

    // Back-to-back: third sample arrives mid-segment; slot fills, then ramps chain.
    do_reset(1'b0);
    got_q.delete();
    cycle(1'b0, 1'b1, 16'sd0);
    cycle(1'b0, 1'b1, 16'sd40);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 16'sd0);
    cycle(1'b1, 1'b1, 16'sd7);
    repeat (6) cycle(1'b1, 1'b0, '0);
    seq_a = '{0, 10, 20, 30, 40, 30, 20, 10, 0, 0};
    for (int i = 0; i < 9; i++)
      check("b2b", (i < got_q.size()) ? longint'(got_q[i]) : -999999, seq_a[i]);

    // Reset at k=2 abandons the segment; later ticks stay silent.
    do_reset(1'b0);
    cycle(1'b0, 1'b1, 16'sd0);
    cycle(1'b0, 1'b1, 16'sd100);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    do_reset(1'b1);
    got_q.delete();
    repeat (4) cycle(1'b1, 1'b0, '0);
    check("post_rst_silent", got_q.size(), 0);

    // Bypass.
    bus.enable = 1'b0;
    got_q.delete();
    cycle(1'b0, 1'b1, 16'sd42);
    check("bypass_42", (got_q.size() == 1) ? longint'(got_q[0]) : -999999, 42);
    cycle(1'b1, 1'b0, 16'sd5);
    bus.enable = 1'b1;

    // Random traffic with occasional bypass windows and resets.
    for (int n = 0; n < 4000; n++) begin
      logic                tick, vld;
      logic signed [W-1:0] d;
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 199) == 0) bus.enable = ~bus.enable;
      tick = (n % 1000 < 500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      vld  = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 1) == 1) d = W'($urandom_range(0, 65535));
      else                           d = W'(int'($urandom_range(0, 200)) - 100);
      cycle(tick, vld, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
